// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo family (fifo, fifo_reader, fifo_skid_buf).
package fifo_pkg;

    typedef enum logic {RUN, DRAIN} reader_state_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer with occupancy tracking: write into the next free slot,
// shift head out on a downstream handshake, clear discards all entries.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter type         DTYPE      = logic [DATA_WIDTH-1:0]
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       wr_i,
    input  DTYPE       wr_data_i,
    input  logic       shift_i,
    output logic [1:0] occ_o,
    output DTYPE       head_o
);

    DTYPE       buf_q [SKID_DEPTH];
    DTYPE       buf_d [SKID_DEPTH];
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic [1:0] wr_idx;

    // Slot the incoming entry lands in: one lower when the head leaves this cycle
    assign wr_idx = occ_q - {1'b0, shift_i};

    // Next buffer contents and occupancy
    always_comb begin
        buf_d = buf_q;
        occ_d = occ_q;
        if (clear_i) begin
            occ_d = '0;
        end else begin
            if (shift_i) begin
                buf_d[0] = buf_q[1];
            end
            if (wr_i) begin
                buf_d[wr_idx[0]] = wr_data_i;
            end
            occ_d = occ_q + {1'b0, wr_i} - {1'b0, shift_i};
        end
    end

    // Buffer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            buf_q <= buf_d;
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = buf_q[0];

endmodule

// File: rtl/fifo_reader.sv
// Consumer-side companion to fifo: pops the upstream FIFO into a 2-entry skid
// buffer, presents entries on a valid/ready stream, and drains on request.
// Optional statistics counters: FIFO_READER_STATS_EN.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter type         DTYPE      = logic [DATA_WIDTH-1:0],
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fifo_empty_i,
    input  DTYPE                  fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output DTYPE                  data_o,
    input  logic                  drain_i,
    output logic                  drain_busy_o,
    output logic [STAT_WIDTH-1:0] pop_count_o,
    output logic [STAT_WIDTH-1:0] drop_count_o
);

    reader_state_e state_q;
    reader_state_e state_d;
    logic [1:0]    occ;
    logic          run;
    logic          handshake;
    logic          buf_wr;
    logic          buf_clear;

    assign run       = (state_q == RUN);
    assign valid_o   = run & (occ != 2'd0);
    assign handshake = valid_o & ready_i;
    assign buf_wr    = run & fifo_pop_o;
    // Clear has priority inside the buffer, so an entry popped on the drain
    // start cycle is discarded along with the buffered ones.
    assign buf_clear = run & drain_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: drain request enters DRAIN, empty FIFO returns to RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_i) state_d = DRAIN;
            DRAIN:   if (fifo_empty_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output logic: pop never looks at ready_i; no pop while reset is held
    always_comb begin
        fifo_pop_o   = 1'b0;
        drain_busy_o = 1'b0;
        case (state_q)
            RUN: begin
                fifo_pop_o = rst_ni & ~fifo_empty_i & (occ < 2'(SKID_DEPTH));
            end
            DRAIN: begin
                fifo_pop_o   = rst_ni & ~fifo_empty_i;
                drain_busy_o = 1'b1;
            end
            default: begin
                fifo_pop_o   = 1'b0;
                drain_busy_o = 1'b0;
            end
        endcase
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DTYPE      (DTYPE)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (buf_clear),
        .wr_i      (buf_wr),
        .wr_data_i (fifo_data_i),
        .shift_i   (handshake),
        .occ_o     (occ),
        .head_o    (data_o)
    );

`ifdef FIFO_READER_STATS_EN
    logic [STAT_WIDTH-1:0] pop_cnt_q;
    logic [STAT_WIDTH-1:0] drop_cnt_q;
    logic [1:0]            drop_inc;
    logic [STAT_WIDTH:0]   pop_sum;
    logic [STAT_WIDTH:0]   drop_sum;

    // Entries discarded this cycle: buffer leftovers at drain start, or a drain pop
    always_comb begin
        drop_inc = '0;
        if (buf_clear) begin
            drop_inc = occ + {1'b0, fifo_pop_o} - {1'b0, handshake};
        end else if (!run) begin
            drop_inc = {1'b0, fifo_pop_o};
        end
    end

    assign pop_sum  = {1'b0, pop_cnt_q}  + (STAT_WIDTH+1)'(handshake);
    assign drop_sum = {1'b0, drop_cnt_q} + (STAT_WIDTH+1)'(drop_inc);

    // Saturating statistics counters
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pop_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pop_cnt_q  <= pop_sum[STAT_WIDTH]  ? '1 : pop_sum[STAT_WIDTH-1:0];
            drop_cnt_q <= drop_sum[STAT_WIDTH] ? '1 : drop_sum[STAT_WIDTH-1:0];
        end
    end

    assign pop_count_o  = pop_cnt_q;
    assign drop_count_o = drop_cnt_q;
`else
    assign pop_count_o  = '0;
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: behavioural upstream FIFO plus a
// scoreboard of expected deliveries. Stats expectations follow FIFO_READER_STATS_EN.
module tb_fifo_reader;

`ifdef FIFO_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        fifo_empty_i;
    logic [31:0] fifo_data_i;
    logic        fifo_pop_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        drain_i;
    logic        drain_busy_o;
    logic [31:0] pop_count_o;
    logic [31:0] drop_count_o;

    always #5 clk = ~clk;

    fifo_reader #(
        .DATA_WIDTH (32),
        .STAT_WIDTH (32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .drain_i      (drain_i),
        .drain_busy_o (drain_busy_o),
        .pop_count_o  (pop_count_o),
        .drop_count_o (drop_count_o)
    );

    logic [31:0] fq[$];
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic        s_pop, s_valid, s_hs, s_busy;
    logic [31:0] s_data;

    task automatic refresh_fifo();
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() == 0) ? 32'hDEAD_BEEF : fq[0];
    endtask

    task automatic push(input logic [31:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
        refresh_fifo();
    endtask

    // One clock: sample outputs before the edge, apply the upstream pop after it
    task automatic tick();
        #1;
        s_pop   = fifo_pop_o;
        s_valid = valid_o;
        s_data  = data_o;
        s_hs    = valid_o & ready_i;
        s_busy  = drain_busy_o;
        @(posedge clk);
        #1;
        if (s_pop === 1'b1 && fq.size() > 0) void'(fq.pop_front());
        refresh_fifo();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        drain_i = 1'b0;
        ready_i = 1'b0;
        fq.delete();
        exp_q.delete();
        refresh_fifo();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        drain_i = 1'b0;
        ready_i = 1'b0;
        fq.delete();
        exp_q.delete();
        push(32'h1); push(32'h2); push(32'h3);
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (s_pop !== 1'b0) begin n_bad++; $display("FAIL reset_pop: got %b want 0", s_pop); end
            n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", s_valid); end
            n_cmp++; if (s_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", s_data); end
        end
        n_cmp++; if (drain_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", drain_busy_o); end
        n_cmp++; if (pop_count_o !== 32'h0) begin n_bad++; $display("FAIL reset_pop_count: got %0d want 0", pop_count_o); end
        n_cmp++; if (drop_count_o !== 32'h0) begin n_bad++; $display("FAIL reset_drop_count: got %0d want 0", drop_count_o); end
        n_cmp++; if (fq.size() != 3) begin n_bad++; $display("FAIL reset_fifo_untouched: got %0d want 3", fq.size()); end
        fq.delete();
        exp_q.delete();
        refresh_fifo();
        rst_ni = 1'b1;
    endtask

    task automatic test_streaming();
        int first_pop = -1, first_hs = -1, last_hs = -1, n_hs = 0;
        logic [31:0] e;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) push(32'h10 + i);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop && first_pop < 0) first_pop = c;
            if (s_hs) begin
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                n_hs++;
                e = exp_q.pop_front();
                n_cmp++; if (s_data !== e) begin n_bad++; $display("FAIL stream_data: got %h want %h", s_data, e); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stream_timeout: got %0d left want 0", exp_q.size()); end
        n_cmp++; if (first_hs != first_pop + 1) begin n_bad++; $display("FAIL stream_latency: got first_hs %0d want %0d", first_hs, first_pop + 1); end
        n_cmp++; if (last_hs - first_hs != 7) begin n_bad++; $display("FAIL stream_consecutive: got span %0d want 7", last_hs - first_hs); end
        tick();
        n_cmp++; if (pop_count_o !== (STATS ? 32'd8 : 32'd0)) begin n_bad++; $display("FAIL stream_pop_count: got %0d want %0d", pop_count_o, STATS ? 8 : 0); end
        n_cmp++; if (drop_count_o !== 32'd0) begin n_bad++; $display("FAIL stream_drop_count: got %0d want 0", drop_count_o); end
    endtask

    task automatic test_backpressure();
        int pops = 0, n_hs = 0;
        logic [31:0] e;
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h20 + i);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_pop) pops++;
            if (s_valid) begin
                n_cmp++; if (s_data !== 32'h20) begin n_bad++; $display("FAIL stall_hold: got %h want 00000020", s_data); end
            end
        end
        n_cmp++; if (pops != 2) begin n_bad++; $display("FAIL stall_pops: got %0d want 2", pops); end
        n_cmp++; if (fq.size() != 3) begin n_bad++; $display("FAIL stall_fifo_left: got %0d want 3", fq.size()); end
        n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", s_valid); end
        ready_i = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tick();
            if (s_hs) begin
                n_hs++;
                e = exp_q.pop_front();
                n_cmp++; if (s_data !== e) begin n_bad++; $display("FAIL stall_release_data: got %h want %h", s_data, e); end
            end
        end
        n_cmp++; if (n_hs != 5) begin n_bad++; $display("FAIL stall_delivered: got %0d want 5", n_hs); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_dup: got valid %b want 0", s_valid); end
        end
    endtask

    task automatic test_drain();
        int drain_pops = 0;
        logic fell = 1'b0;
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(32'h30 + i);
        for (int c = 0; c < 3; c++) tick();
        n_cmp++; if (fq.size() != 4) begin n_bad++; $display("FAIL drain_prefill: got %0d want 4", fq.size()); end
        drain_i = 1'b1;
        tick();
        drain_i = 1'b0;
        tick();
        n_cmp++; if (s_busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy_start: got %b want 1", s_busy); end
        if (s_pop) drain_pops++;
        for (int c = 0; c < 20; c++) begin
            n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %b want 0", s_valid); end
            tick();
            if (!s_busy) begin fell = 1'b1; break; end
            if (s_pop) drain_pops++;
        end
        n_cmp++; if (!fell) begin n_bad++; $display("FAIL drain_busy_fall: got busy stuck want 0"); end
        n_cmp++; if (drain_pops != 4) begin n_bad++; $display("FAIL drain_pops: got %0d want 4", drain_pops); end
        n_cmp++; if (fq.size() != 0) begin n_bad++; $display("FAIL drain_empty: got %0d want 0", fq.size()); end
        n_cmp++; if (drop_count_o !== (STATS ? 32'd6 : 32'd0)) begin n_bad++; $display("FAIL drain_drop_count: got %0d want %0d", drop_count_o, STATS ? 6 : 0); end
        n_cmp++; if (pop_count_o !== 32'd0) begin n_bad++; $display("FAIL drain_pop_count: got %0d want 0", pop_count_o); end
        exp_q.delete();
    endtask

    task automatic test_drain_handshake();
        logic fell = 1'b0;
        logic [31:0] e;
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(32'h40 + i);
        for (int c = 0; c < 3; c++) tick();
        ready_i = 1'b1;
        drain_i = 1'b1;
        tick();
        ready_i = 1'b0;
        drain_i = 1'b0;
        n_cmp++; if (s_hs !== 1'b1) begin n_bad++; $display("FAIL drain_hs_valid: got %b want 1", s_hs); end
        e = exp_q.pop_front();
        n_cmp++; if (s_data !== e) begin n_bad++; $display("FAIL drain_hs_data: got %h want %h", s_data, e); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!s_busy) begin fell = 1'b1; break; end
        end
        n_cmp++; if (!fell) begin n_bad++; $display("FAIL drain_hs_busy_fall: got busy stuck want 0"); end
        n_cmp++; if (pop_count_o !== (STATS ? 32'd1 : 32'd0)) begin n_bad++; $display("FAIL drain_hs_pop_count: got %0d want %0d", pop_count_o, STATS ? 1 : 0); end
        n_cmp++; if (drop_count_o !== (STATS ? 32'd5 : 32'd0)) begin n_bad++; $display("FAIL drain_hs_drop_count: got %0d want %0d", drop_count_o, STATS ? 5 : 0); end
        exp_q.delete();
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h50 + i);
        for (int c = 0; c < 3; c++) tick();
        drain_i = 1'b1;
        tick();
        drain_i = 1'b0;
        tick();
        tick();
        n_cmp++; if (fq.size() != 4) begin n_bad++; $display("FAIL rstdrain_pre: got %0d want 4", fq.size()); end
        rst_ni = 1'b0;
        tick();
        n_cmp++; if (s_pop !== 1'b0) begin n_bad++; $display("FAIL rstdrain_pop: got %b want 0", s_pop); end
        tick();
        n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL rstdrain_busy: got %b want 0", s_busy); end
        n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rstdrain_valid: got %b want 0", s_valid); end
        n_cmp++; if (fq.size() != 4) begin n_bad++; $display("FAIL rstdrain_untouched: got %0d want 4", fq.size()); end
        fq.delete();
        exp_q.delete();
        refresh_fifo();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        rst_ni       = 1'b0;
        ready_i      = 1'b0;
        drain_i      = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = 32'h0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain();
        test_drain_handshake();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
